// File: rtl/decryption_out_packer.sv
// decryption_out_packer: packs decrypted bytes little-endian into 32-bit words,
// buffers them in a first-word-fall-through FIFO and drains them over valid/ready.
// A full FIFO with no pop in the same cycle drops the word and sets a sticky flag.
// Optional feature macro: DEC_OUT_STATS_EN (adds byte_cnt_o and drop_cnt_o).
module decryption_out_packer #(
  parameter int SYS_DWIDTH = 8,
  parameter int OUT_DWIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4
) (
  input  logic                  clk_sys,
  input  logic                  rst_n,
  input  logic [SYS_DWIDTH-1:0] data_i,
  input  logic                  valid_i,
  input  logic                  flush_i,
  input  logic                  clr_ovf_i,
  output logic [OUT_DWIDTH-1:0] data_o,
  output logic [3:0]            byte_en_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [ADDR_W:0]       level_o,
  output logic                  full_o,
  output logic                  overflow_o
`ifdef DEC_OUT_STATS_EN
  ,
  output logic [15:0]           byte_cnt_o,
  output logic [15:0]           drop_cnt_o
`endif
);

  logic [1:0]            lane;
  logic [OUT_DWIDTH-1:0] pack;
  logic [OUT_DWIDTH-1:0] pack_nxt;
  logic [2:0]            cnt_nxt;
  logic                  push;
  logic [3:0]            push_be;
  logic                  pop;
  logic                  accept;
  logic                  drop;

  logic [ADDR_W-1:0]     wr_ptr;
  logic [ADDR_W-1:0]     rd_ptr;
  logic [ADDR_W:0]       level;
  logic [OUT_DWIDTH-1:0] mem_data [DEPTH];
  logic [3:0]            mem_be   [DEPTH];

  // Packer next state: the incoming byte is merged first, so a flush in the same
  // cycle sees it and a completing byte yields exactly one full word.
  always_comb begin
    pack_nxt = pack;
    if (valid_i) pack_nxt[{lane, 3'b000} +: SYS_DWIDTH] = data_i;
    cnt_nxt  = {1'b0, lane} + {2'b00, valid_i};
    push     = (cnt_nxt == 3'd4) || (flush_i && (cnt_nxt != 3'd0));
    push_be  = 4'((5'd1 << cnt_nxt) - 5'd1);
  end

  assign valid_o = (level != '0);
  assign full_o  = (level == (ADDR_W+1)'(DEPTH));
  assign level_o = level;
  assign pop     = valid_o && ready_i;
  assign accept  = push && (!full_o || pop);
  assign drop    = push && full_o && !pop;

  // Head word shown straight from storage; forced to zero while the FIFO is empty.
  assign data_o    = valid_o ? mem_data[rd_ptr] : '0;
  assign byte_en_o = valid_o ? mem_be[rd_ptr]   : 4'b0000;

  // Lane counter and packing register; both clear whenever a word leaves the packer.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      lane <= 2'd0;
      pack <= '0;
    end else if (push) begin
      lane <= 2'd0;
      pack <= '0;
    end else begin
      lane <= cnt_nxt[1:0];
      pack <= pack_nxt;
    end
  end

  // FIFO storage is data only and needs no reset.
  always_ff @(posedge clk_sys) begin
    if (accept) begin
      mem_data[wr_ptr] <= pack_nxt;
      mem_be[wr_ptr]   <= push_be;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n)         overflow_o <= 1'b0;
    else if (drop)      overflow_o <= 1'b1;
    else if (clr_ovf_i) overflow_o <= 1'b0;
  end

`ifdef DEC_OUT_STATS_EN
  // Statistics: byte count wraps, drop count saturates.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_o <= 16'd0;
      drop_cnt_o <= 16'd0;
    end else begin
      if (valid_i) byte_cnt_o <= byte_cnt_o + 16'd1;
      if (drop && (drop_cnt_o != 16'hFFFF)) drop_cnt_o <= drop_cnt_o + 16'd1;
    end
  end
`endif

endmodule
